softmax_result_collector: RTL

- Sink for the SOFTMAX_TOP output stream (softmax_out_final qualified by valid_data).
- Captures one frame of IFM_SIZE probabilities into an internal buffer.
- Tracks the running sum and the argmax while capturing.
- Holds the completed frame for random-access readout until the consumer acknowledges it.

---
 rtl/softmax_pkg.sv | 35 +++
 rtl/softmax_result_ram.sv | 43 ++++
 rtl/softmax_result_collector.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/softmax_pkg.sv
// Shared definitions for the softmax result collector: default sample width,
// FSM state encoding and a constant clog2 helper used for width derivation.
package softmax_pkg;

    localparam int DATA_WIDTH_OUT_DEF = 24;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    // Minimum bits needed to index 'value' entries; never returns less than 1.
    function automatic int sm_clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        for (int i = 0; i < 32; i++) begin
            if (rem > 0) begin
                result = result + 1;
                rem    = rem >> 1;
            end else begin
                rem = rem;
            end
        end
        if (result == 0) begin
            result = 1;
        end else begin
            result = result;
        end
        return result;
    endfunction

endpackage

// File: rtl/softmax_result_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port with
// one cycle of latency. Reads beyond DEPTH return zero.
module softmax_result_ram
    import softmax_pkg::*;
#(
    parameter int DW    = DATA_WIDTH_OUT_DEF,
    parameter int DEPTH = 1000,
    parameter int AW    = sm_clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    localparam int IW = sm_clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    // Storage array write; the array itself carries no reset.
    always_ff @(posedge clk) begin
        if (we && (int'(waddr) < DEPTH)) begin
            mem_q[waddr[IW-1:0]] <= wdata;
        end
    end

    // Read register; only the output register is reset so rdata starts at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= (int'(raddr) < DEPTH) ? mem_q[raddr[IW-1:0]] : '0;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/softmax_result_collector.sv
// Captures one frame of softmax probabilities, tracking running sum and argmax,
// then holds the frame for random-access readout until the consumer acks it.
module softmax_result_collector
    import softmax_pkg::*;
#(
    parameter int DATA_WIDTH_OUT = DATA_WIDTH_OUT_DEF,
    parameter int IFM_SIZE       = 1000,
    parameter int ADDR_WIDTH     = sm_clog2(IFM_SIZE),
    parameter int SUM_WIDTH      = DATA_WIDTH_OUT + ADDR_WIDTH
) (
    input  logic                      clk1,
    input  logic                      rst_n,
    input  logic                      valid_data,
    input  logic [DATA_WIDTH_OUT-1:0] softmax_out_final,
    input  logic                      frame_ack,
    input  logic                      rd_en,
    input  logic [ADDR_WIDTH-1:0]     rd_addr,
    output logic [DATA_WIDTH_OUT-1:0] rd_data,
    output logic                      rd_valid,
    output logic                      frame_done,
    output logic [ADDR_WIDTH-1:0]     argmax_idx,
    output logic [DATA_WIDTH_OUT-1:0] argmax_val,
    output logic [SUM_WIDTH-1:0]      prob_sum,
    output logic                      busy,
    output logic                      overflow
);

    // One extra counter bit so the count can reach IFM_SIZE even at 2^ADDR_WIDTH.
    localparam int             CW       = ADDR_WIDTH + 1;
    localparam logic [CW-1:0]  LAST_CNT = CW'(IFM_SIZE - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1'b1);

    state_e                    state_q, state_d;
    logic [CW-1:0]             wr_cnt_q, wr_cnt_d;
    logic [SUM_WIDTH-1:0]      sum_q, sum_d;
    logic [ADDR_WIDTH-1:0]     amax_idx_q, amax_idx_d;
    logic [DATA_WIDTH_OUT-1:0] amax_val_q, amax_val_d;
    logic                      frame_done_q, frame_done_d;
    logic                      busy_q, busy_d;
    logic                      overflow_q, overflow_d;
    logic                      rd_valid_q, rd_valid_d;

    logic                      start_s;
    logic                      wr_en_s;
    logic [ADDR_WIDTH-1:0]     wr_addr_s;
    logic                      rd_fire_s;
    logic [SUM_WIDTH-1:0]      sample_ext_s;

    assign sample_ext_s = SUM_WIDTH'(softmax_out_final);
    assign start_s      = valid_data &&
                          ((state_q == ST_IDLE) || ((state_q == ST_DONE) && frame_ack));
    assign rd_fire_s    = rd_en && (state_q == ST_DONE);

    // Next-state, capture datapath and flag logic.
    always_comb begin
        state_d      = state_q;
        wr_cnt_d     = wr_cnt_q;
        sum_d        = sum_q;
        amax_idx_d   = amax_idx_q;
        amax_val_d   = amax_val_q;
        frame_done_d = 1'b0;
        overflow_d   = overflow_q;
        wr_en_s      = 1'b0;
        wr_addr_s    = '0;

        if (start_s) begin
            wr_en_s    = 1'b1;
            wr_addr_s  = '0;
            wr_cnt_d   = CNT_ONE;
            sum_d      = sample_ext_s;
            amax_idx_d = '0;
            amax_val_d = softmax_out_final;
            if (IFM_SIZE == 1) begin
                state_d      = ST_DONE;
                frame_done_d = 1'b1;
            end else begin
                state_d = ST_COLLECT;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_COLLECT: begin
                    if (valid_data) begin
                        wr_en_s   = 1'b1;
                        wr_addr_s = wr_cnt_q[ADDR_WIDTH-1:0];
                        wr_cnt_d  = wr_cnt_q + CNT_ONE;
                        sum_d     = sum_q + sample_ext_s;
                        // Strictly greater keeps the lowest index on ties.
                        if (softmax_out_final > amax_val_q) begin
                            amax_idx_d = wr_cnt_q[ADDR_WIDTH-1:0];
                            amax_val_d = softmax_out_final;
                        end else begin
                            amax_idx_d = amax_idx_q;
                        end
                        if (wr_cnt_q == LAST_CNT) begin
                            state_d      = ST_DONE;
                            frame_done_d = 1'b1;
                        end else begin
                            state_d = ST_COLLECT;
                        end
                    end else begin
                        state_d = ST_COLLECT;
                    end
                end
                ST_DONE: begin
                    if (frame_ack) begin
                        state_d    = ST_IDLE;
                        wr_cnt_d   = '0;
                        sum_d      = '0;
                        amax_idx_d = '0;
                        amax_val_d = '0;
                    end else if (valid_data) begin
                        overflow_d = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d     = (state_d == ST_COLLECT);
        rd_valid_d = rd_fire_s;
    end

    // State and output registers.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            wr_cnt_q     <= '0;
            sum_q        <= '0;
            amax_idx_q   <= '0;
            amax_val_q   <= '0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            overflow_q   <= 1'b0;
            rd_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_cnt_q     <= wr_cnt_d;
            sum_q        <= sum_d;
            amax_idx_q   <= amax_idx_d;
            amax_val_q   <= amax_val_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
            overflow_q   <= overflow_d;
            rd_valid_q   <= rd_valid_d;
        end
    end

    softmax_result_ram #(
        .DW    (DATA_WIDTH_OUT),
        .DEPTH (IFM_SIZE),
        .AW    (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk1),
        .rst_n (rst_n),
        .we    (wr_en_s),
        .waddr (wr_addr_s),
        .wdata (softmax_out_final),
        .re    (rd_fire_s),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    assign rd_valid   = rd_valid_q;
    assign frame_done = frame_done_q;
    assign argmax_idx = amax_idx_q;
    assign argmax_val = amax_val_q;
    assign prob_sum   = sum_q;
    assign busy       = busy_q;
    assign overflow   = overflow_q;

endmodule
